wb_arbiter: RTL and testbench

Writeback arbiter between the execute/memory pipeline and the integer register file. It merges in-order pipeline results with out-of-order results from the long-latency multiply/divide unit (MDU) onto the register file's single write port. MDU results wait in a small FIFO; pipeline results always take priority. A per-register busy scoreboard lets the hazard unit stall readers of registers with an MDU write still pending.

---
 rtl/wb_pkg.sv | 9 +
 rtl/wb_fifo.sv | 36 +++
 rtl/wb_arbiter.sv | 71 +++++++
 tb/tb_wb_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter
package wb_pkg;
   localparam int XLEN = 32;
   localparam int REG_COUNT = 32;
   typedef struct packed {
      logic [4:0]      waddr;
      logic [XLEN-1:0] wdata;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries with wrapping pointers and occupancy count
module wb_fifo import wb_pkg::*; #(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push,
   input  logic        pop,
   input  wb_entry_t   din,
   output logic        full,
   output logic        empty,
   output wb_entry_t   head,
   output logic [AW:0] level
);
   wb_entry_t mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign head = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges pipeline and MDU results onto the register-file write port, with busy scoreboard.
// Define WB_BYPASS_EN to let an MDU result skip an empty FIFO when the pipeline is idle.
module wb_arbiter import wb_pkg::*; #(
   parameter int XLEN = wb_pkg::XLEN,
   parameter int FIFO_DEPTH = 2,
   localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pipe_wen,
   input  logic [4:0]           pipe_waddr,
   input  logic [XLEN-1:0]      pipe_wdata,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   input  logic                 mdu_valid,
   output logic                 mdu_ready,
   input  logic [4:0]           mdu_waddr,
   input  logic [XLEN-1:0]      mdu_wdata,
   output logic                 reg_write,
   output logic [4:0]           waddr,
   output logic [XLEN-1:0]      wdata,
   output logic [REG_COUNT-1:0] busy_mask,
   output logic [LW-1:0]        fifo_level
);
   wb_entry_t head, mdu_entry;
   logic full, empty, pipe_sel, pop, push, bypass, from_mdu;
   logic nxt_write, nxt_mdu;
   logic [4:0] nxt_waddr;
   logic [XLEN-1:0] nxt_wdata;
   logic [REG_COUNT-1:0] set_mask, clr_mask;
   assign pipe_sel = pipe_wen && pipe_waddr != 5'd0;
   assign pop = !pipe_sel && !empty;
`ifdef WB_BYPASS_EN
   assign bypass = empty && mdu_valid && !pipe_sel;
`else
   assign bypass = 1'b0;
`endif
   assign mdu_ready = !full;
   assign push = mdu_valid && mdu_ready && !bypass;
   assign mdu_entry = '{waddr: mdu_waddr, wdata: mdu_wdata};
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(mdu_entry),
      .full(full), .empty(empty), .head(head), .level(fifo_level)
   );
   // x0 targets are consumed but never written
   always_comb begin
      nxt_waddr = pipe_sel ? pipe_waddr : pop ? head.waddr : mdu_waddr;
      nxt_wdata = pipe_sel ? pipe_wdata : pop ? head.wdata : mdu_wdata;
      nxt_mdu = !pipe_sel && (pop || bypass);
      nxt_write = (pipe_sel || nxt_mdu) && nxt_waddr != 5'd0;
   end
   assign set_mask = issue_valid ? REG_COUNT'(1) << issue_rd : '0;
   assign clr_mask = (reg_write && from_mdu) ? REG_COUNT'(1) << waddr : '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         reg_write <= 1'b0;
         waddr <= '0;
         wdata <= '0;
         from_mdu <= 1'b0;
         busy_mask <= '0;
      end else begin
         reg_write <= nxt_write;
         from_mdu <= nxt_mdu;
         if (nxt_write) begin
            waddr <= nxt_waddr;
            wdata <= nxt_wdata;
         end
         busy_mask <= ((busy_mask & ~clr_mask) | set_mask) & ~REG_COUNT'(1);
      end
   assert property (@(posedge clk) disable iff (reset) !(pipe_wen && busy_mask[pipe_waddr]));
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized scoreboard bench for wb_arbiter against a queue-based reference model
module tb_wb_arbiter;
   localparam int DEPTH = 2;
   logic clk = 1'b0;
   logic reset;
   logic pipe_wen, issue_valid, mdu_valid;
   logic [4:0] pipe_waddr, issue_rd, mdu_waddr;
   logic [31:0] pipe_wdata, mdu_wdata;
   logic mdu_ready, reg_write;
   logic [4:0] waddr;
   logic [31:0] wdata, busy_mask;
   logic [1:0] fifo_level;

   typedef struct {int cyc; logic [4:0] a; logic [31:0] d;} exp_t;
   typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
   exp_t exp_q[$];
   ent_t m_fifo[$];
   exp_t e_mon;
   logic [31:0] m_busy = '0;
   logic m_clr_v = 1'b0;
   logic [4:0] m_clr_a = '0;
   bit m_taken;
   int cyc = 0, errors = 0, checks = 0;

   wb_arbiter dut (
      .clk(clk), .reset(reset), .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
      .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata), .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
      .busy_mask(busy_mask), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", n, act, req, cyc);
      end
   endtask

   // Reference model: applies one clock edge using the current inputs
   task automatic model_edge();
      bit psel, rdy, byp;
      logic [31:0] nb;
      ent_t e;
      psel = pipe_wen && pipe_waddr != 0;
      rdy = m_fifo.size() < DEPTH;
      byp = 0;
`ifdef WB_BYPASS_EN
      byp = m_fifo.size() == 0 && mdu_valid && !psel;
`endif
      nb = m_busy;
      if (m_clr_v) nb[m_clr_a] = 1'b0;
      if (issue_valid) nb[issue_rd] = 1'b1;
      nb[0] = 1'b0;
      m_clr_v = 0;
      if (psel) exp_q.push_back('{cyc + 1, pipe_waddr, pipe_wdata});
      else if (m_fifo.size() > 0) begin
         e = m_fifo.pop_front();
         if (e.a != 0) begin
            exp_q.push_back('{cyc + 1, e.a, e.d});
            m_clr_v = 1;
            m_clr_a = e.a;
         end
      end else if (byp && mdu_waddr != 0) begin
         exp_q.push_back('{cyc + 1, mdu_waddr, mdu_wdata});
         m_clr_v = 1;
         m_clr_a = mdu_waddr;
      end
      m_taken = mdu_valid && (byp || rdy);
      if (mdu_valid && rdy && !byp) m_fifo.push_back('{mdu_waddr, mdu_wdata});
      m_busy = nb;
      cyc++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (m_taken) mdu_valid = 1'b0;
   endtask

   task automatic drive(bit pw, int pa, logic [31:0] pd, bit iv, int ir);
      pipe_wen = pw;
      pipe_waddr = 5'(pa);
      pipe_wdata = pd;
      issue_valid = iv;
      issue_rd = 5'(ir);
   endtask

   task automatic offer(int a, logic [31:0] d);
      mdu_valid = 1'b1;
      mdu_waddr = 5'(a);
      mdu_wdata = d;
   endtask

   always @(negedge clk) if (!reset) begin
      chk("busy_mask", busy_mask, m_busy);
      chk("fifo_level", fifo_level, m_fifo.size());
      chk("mdu_ready", mdu_ready, m_fifo.size() < DEPTH);
      if (reg_write) begin
         chk("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            e_mon = exp_q.pop_front();
            chk("write_cycle", cyc, e_mon.cyc);
            chk("waddr", waddr, e_mon.a);
            chk("wdata", wdata, e_mon.d);
         end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
         chk("reg_write", reg_write, 1);
         void'(exp_q.pop_front());
      end
   end

   initial begin
      int n;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0);
      mdu_valid = 1'b0;
      mdu_waddr = '0;
      mdu_wdata = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_reg_write", reg_write, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", mdu_ready, 1);
      // pipeline write, single pulse
      drive(1, 5, 32'hDEADBEEF, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (2) tick();
      // scoreboard set and clear for x7
      drive(0, 0, 0, 1, 7);
      tick();
      drive(0, 0, 0, 0, 0);
      tick();
      offer(7, 32'h12345678);
      repeat (4) tick();
      // pipeline starves the FIFO, then drains in order
      n = 0;
      for (int i = 0; i < 11; i++) begin
         if (!mdu_valid && n < 3) begin
            offer(16 + n, 32'h1000 + n);
            n++;
         end
         drive(i < 6, 21 + i, 32'h2000 + i, 0, 0);
         tick();
      end
      // x0 pipeline write does not block a pop
      drive(1, 11, 32'h11, 0, 0);
      offer(3, 32'hA5);
      tick();
      drive(1, 0, 32'hFFFF, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (2) tick();
      // re-issue to x9 on the commit edge keeps it busy
      drive(0, 0, 0, 1, 9);
      tick();
      drive(0, 0, 0, 0, 0);
      offer(9, 32'h99);
      tick();
`ifndef WB_BYPASS_EN
      tick();
`endif
      drive(0, 0, 0, 1, 9);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (2) tick();
      chk("busy9_held", busy_mask[9], 1);
      // reset with FIFO full and busy {4,6}
      drive(1, 12, 32'hC, 1, 4);
      offer(4, 32'h44);
      tick();
      drive(1, 13, 32'hD, 1, 6);
      offer(6, 32'h66);
      tick();
      drive(1, 14, 32'hE, 0, 0);
      chk("pre_full", fifo_level, DEPTH);
      @(posedge clk);
      model_edge();
      #2 reset = 1'b1;
      #1;
      chk("async_level", fifo_level, 0);
      chk("async_busy", busy_mask, 0);
      chk("async_reg_write", reg_write, 0);
      chk("async_ready", mdu_ready, 1);
      m_fifo.delete();
      exp_q.delete();
      m_busy = '0;
      m_clr_v = 0;
      drive(0, 0, 0, 0, 0);
      mdu_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int a;
         a = $urandom_range(0, 31);
         if (m_busy[a]) a = 0;
         drive($urandom_range(0, 99) < 45, a, $urandom, $urandom_range(0, 99) < 30, $urandom_range(0, 31));
         if (!mdu_valid && $urandom_range(0, 99) < 50) offer($urandom_range(0, 31), $urandom);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      repeat (8) tick();
      chk("drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
